// File: rtl/buzzer_scheduler_pkg.sv
// Shared types for the buzzer scheduler: FSM state encoding, note field
// widths and the queued note entry.
package buzzer_scheduler_pkg;

  localparam int unsigned PERIOD_W = 16;
  localparam int unsigned DUR_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic [PERIOD_W-1:0] period;
    logic [DUR_W-1:0]    dur;
  } note_t;

endpackage

// File: rtl/buzzer_note_fifo.sv
// Note queue for the buzzer scheduler. DEPTH must be a power of two >= 2.
// A push into a full queue is taken only when a pop happens in the same
// cycle; a pop on an empty queue is ignored. flush empties the queue.
module buzzer_note_fifo
  import buzzer_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      push,
  input  note_t                     push_data,
  input  logic                      pop,
  output note_t                     pop_data,
  output logic                      push_ok,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int unsigned AW = $clog2(DEPTH);

  note_t        mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         pop_ok;

  // Status flags and accept decisions come straight from the pointers.
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    level    = wr_ptr - rd_ptr;
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    pop_data = mem[rd_ptr[AW-1:0]];
  end

  // Pointer update; flush and reset both return the queue to empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; when full with a pop, the write slot is the one being
  // read this cycle, so the popped entry is captured before it is replaced.
  always_ff @(posedge clk) begin
    if (push_ok && !flush && !rst) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/buzzer_scheduler.sv
// Buzzer note scheduler: queues {half-period, duration} notes and plays
// them back as a square wave on BUZ.
// Optional feature macro: BUZZER_SCHED_GAP_EN inserts a PRESCALE-cycle
// silent gap between consecutive notes (none after the last note).
module buzzer_scheduler
  import buzzer_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PRESCALE = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [PERIOD_W-1:0] wr_period,
  input  logic [DUR_W-1:0]    wr_dur,
  input  logic                start,
  input  logic                stop,
  output logic                full,
  output logic                empty,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic                BUZ
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  state_t              state;
  state_t              state_nx;

  note_t               head;
  note_t               wr_note;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_push_ok;
  logic [AW:0]         fifo_level;

  logic [PERIOD_W-1:0] period_r;
  logic [DUR_W-1:0]    dur_r;
  logic [PW-1:0]       pre_cnt;
  logic [DUR_W-1:0]    unit_cnt;
  logic [PERIOD_W-1:0] tone_cnt;

  logic                pre_last;
  logic                unit_last;
  logic                play_end;
  logic                more_after_pop;
  logic                done_d;
  logic                ovf_d;

  assign wr_note.period = wr_period;
  assign wr_note.dur    = wr_dur;

  // A write in a stop cycle is discarded outright, so it can never flag ovf.
  assign fifo_push = wr_en && !stop;

  buzzer_note_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (stop),
    .push      (fifo_push),
    .push_data (wr_note),
    .pop       (fifo_pop),
    .pop_data  (head),
    .push_ok   (fifo_push_ok),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  // Counter terminal conditions used by the FSM.
  always_comb begin
    pre_last       = (pre_cnt == PW'(PRESCALE - 1));
    unit_last      = (unit_cnt == (dur_r - 16'd1));
    play_end       = pre_last && unit_last;
    more_after_pop = (fifo_level > (AW+1)'(1)) || fifo_push_ok;
    ovf_d          = fifo_push && !fifo_push_ok;
  end

  // Next-state logic, FIFO pop and natural-completion pulse; stop overrides all.
  always_comb begin
    state_nx = state;
    fifo_pop = 1'b0;
    done_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !empty) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        fifo_pop = 1'b1;
        if (head.dur != '0) begin
          state_nx = ST_PLAY;
        end else if (more_after_pop) begin
          state_nx = ST_LOAD;
        end else begin
          state_nx = ST_IDLE;
          done_d   = 1'b1;
        end
      end
      ST_PLAY: begin
        if (play_end) begin
          if (!empty) begin
`ifdef BUZZER_SCHED_GAP_EN
            state_nx = ST_GAP;
`else
            state_nx = ST_LOAD;
`endif
          end else begin
            state_nx = ST_IDLE;
            done_d   = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (pre_last) state_nx = ST_LOAD;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (stop) begin
      state_nx = ST_IDLE;
      fifo_pop = 1'b0;
      done_d   = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Capture the popped note for playback.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_r <= '0;
      dur_r    <= '0;
    end else if (state == ST_LOAD) begin
      period_r <= head.period;
      dur_r    <= head.dur;
    end
  end

  // Duration timing: prescale counter feeds the unit counter while a note
  // or gap continues; everything clears on any state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt  <= '0;
      unit_cnt <= '0;
    end else if (state == ST_PLAY && state_nx == ST_PLAY) begin
      if (pre_last) begin
        pre_cnt  <= '0;
        unit_cnt <= unit_cnt + 16'd1;
      end else begin
        pre_cnt  <= pre_cnt + 1'b1;
      end
    end else if (state == ST_GAP && state_nx == ST_GAP) begin
      pre_cnt  <= pre_cnt + 1'b1;
      unit_cnt <= '0;
    end else begin
      pre_cnt  <= '0;
      unit_cnt <= '0;
    end
  end

  // Tone generator: toggles BUZ every period_r cycles while the note
  // continues; forced low whenever the next state is not PLAY.
  always_ff @(posedge clk) begin
    if (rst) begin
      tone_cnt <= '0;
      BUZ      <= 1'b0;
    end else if (state == ST_PLAY && state_nx == ST_PLAY && period_r != '0) begin
      if (tone_cnt == (period_r - 16'd1)) begin
        tone_cnt <= '0;
        BUZ      <= ~BUZ;
      end else begin
        tone_cnt <= tone_cnt + 16'd1;
      end
    end else begin
      tone_cnt <= '0;
      BUZ      <= 1'b0;
    end
  end

  // Registered one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      done <= done_d;
      ovf  <= ovf_d;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Scoreboard bench for buzzer_scheduler (DEPTH=4, PRESCALE=4).
module tb_buzzer_scheduler;

  localparam int DEPTH = 4;
  localparam int PRE   = 4;
`ifdef BUZZER_SCHED_GAP_EN
  localparam int GAP = PRE;
`else
  localparam int GAP = 0;
`endif

  localparam int EV_BUZ  = 0;
  localparam int EV_DONE = 1;
  localparam int EV_OVF  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_period;
  logic [15:0] wr_dur;
  logic        start;
  logic        stop;
  logic        full;
  logic        empty;
  logic        busy;
  logic        done;
  logic        ovf;
  logic        BUZ;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  ev_t expq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  bit  mon_en = 0;

  buzzer_scheduler #(
    .DEPTH    (DEPTH),
    .PRESCALE (PRE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_period (wr_period),
    .wr_dur    (wr_dur),
    .start     (start),
    .stop      (stop),
    .full      (full),
    .empty     (empty),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .BUZ       (BUZ)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      EV_BUZ:  return "BUZ";
      EV_DONE: return "done";
      default: return "ovf";
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void exp_ev(input int k, input int v, input int c);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.cyc  = c;
    expq.push_back(e);
  endfunction

  // Expected BUZ edges of one note whose first PLAY cycle is p0.
  function automatic void exp_note(input int p0, input int per, input int len);
    bit b = 0;
    if (per > 0) begin
      for (int k = 1; k * per < len; k++) begin
        b = ~b;
        exp_ev(EV_BUZ, int'(b), p0 + k * per);
      end
    end
    if (b) exp_ev(EV_BUZ, 0, p0 + len);
  endfunction

  task automatic cmp_ev(input int k, input int v);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got %s=%0d at cycle %0d, required no event",
               kname(k), kname(k), v, cyc);
    end else begin
      e = expq.pop_front();
      if (e.kind != k || e.val != v || e.cyc != cyc) begin
        errors++;
        $display("FAIL event_%s: got %s=%0d at cycle %0d, required %s=%0d at cycle %0d",
                 kname(k), kname(k), v, cyc, kname(e.kind), e.val, e.cyc);
      end
    end
  endtask

  // Monitor: every observable output event is matched against the queue.
  initial begin
    logic pb;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (BUZ !== pb) begin
          cmp_ev(EV_BUZ, int'(BUZ));
          pb = BUZ;
        end
        if (done !== 1'b0) cmp_ev(EV_DONE, 1);
        if (ovf !== 1'b0)  cmp_ev(EV_OVF, 1);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_note(input int p, input int d);
    wr_en     = 1'b1;
    wr_period = 16'(p);
    wr_dur    = 16'(d);
    tick();
    wr_en     = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (expq.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk({name, "_pending_events"}, 32'(expq.size()), 32'd0);
    expq.delete();
    repeat (6) tick();
  endtask

  initial begin
    int s;
    int p;
    rst = 1'b1; wr_en = 1'b0; wr_period = '0; wr_dur = '0; start = 1'b0; stop = 1'b0;
    repeat (3) tick();
    chk("reset_busy",  32'(busy),  32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full",  32'(full),  32'd0);
    chk("reset_BUZ",   32'(BUZ),   32'd0);
    chk("reset_done",  32'(done),  32'd0);
    chk("reset_ovf",   32'(ovf),   32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Start with an empty queue is ignored.
    pulse_start();
    chk("start_empty_busy", 32'(busy), 32'd0);
    repeat (2) tick();

    // Single note {2,3}: 12 PLAY cycles toggling every 2.
    push_note(2, 3);
    s = cyc;
    exp_note(s + 2, 2, 12);
    exp_ev(EV_DONE, 1, s + 14);
    pulse_start();
    chk("single_busy_after_start", 32'(busy), 32'd1);
    repeat (13) tick();
    chk("single_busy_end", 32'(busy), 32'd0);
    chk("single_empty_end", 32'(empty), 32'd1);
    drain("single");

    // Rest {0,2} then {3,1}; gap build inserts PRESCALE silent cycles.
    push_note(0, 2);
    push_note(3, 1);
    s = cyc;
    exp_note(s + 2, 0, 8);
    exp_note(s + 11 + GAP, 3, 4);
    exp_ev(EV_DONE, 1, s + 15 + GAP);
    pulse_start();
    drain("rest_then_tone");

    // Zero-duration entry is skipped.
    push_note(5, 0);
    push_note(1, 1);
    s = cyc;
    exp_note(s + 3, 1, 4);
    exp_ev(EV_DONE, 1, s + 7);
    pulse_start();
    drain("skip_zero_dur");

    // Fill, overflow drop, then a write accepted alongside the LOAD pop.
    push_note(1, 1);
    push_note(2, 1);
    chk("fill_not_full_2", 32'(full), 32'd0);
    push_note(0, 1);
    push_note(3, 1);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_not_empty", 32'(empty), 32'd0);
    exp_ev(EV_OVF, 1, cyc + 1);
    push_note(7, 9);
    chk("ovf_full_kept", 32'(full), 32'd1);
    repeat (2) tick();
    s = cyc;
    p = s + 2;
    exp_note(p, 1, 4); p = p + 5 + GAP;
    exp_note(p, 2, 4); p = p + 5 + GAP;
    exp_note(p, 0, 4); p = p + 5 + GAP;
    exp_note(p, 3, 4); p = p + 5 + GAP;
    exp_note(p, 1, 8);
    exp_ev(EV_DONE, 1, p + 8);
    pulse_start();
    push_note(1, 2);
    chk("pop_push_full", 32'(full), 32'd1);
    drain("full_sequence");
    chk("full_sequence_empty", 32'(empty), 32'd1);

    // Mid-note stop with a same-cycle start and write.
    push_note(2, 3);
    s = cyc;
    exp_ev(EV_BUZ, 1, s + 4);
    exp_ev(EV_BUZ, 0, s + 6);
    pulse_start();
    repeat (4) tick();
    stop = 1'b1; start = 1'b1; wr_en = 1'b1; wr_period = 16'd7; wr_dur = 16'd7;
    tick();
    stop = 1'b0; start = 1'b0; wr_en = 1'b0;
    chk("stop_busy",  32'(busy),  32'd0);
    chk("stop_empty", 32'(empty), 32'd1);
    chk("stop_BUZ",   32'(BUZ),   32'd0);
    drain("stop");

    // Mid-note reset: no residual edge afterwards.
    push_note(1, 2);
    s = cyc;
    exp_ev(EV_BUZ, 1, s + 3);
    exp_ev(EV_BUZ, 0, s + 4);
    pulse_start();
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_BUZ",   32'(BUZ),   32'd0);
    drain("rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
